fir_mac_seq: RTL

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_mac_pkg.sv | 22 ++
 rtl/fir_mac_round_sat.sv | 49 ++++
 rtl/fir_mac_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fir_mac_pkg.sv
// Shared types and constants for the sequential FIR MAC filter.
// FSM state encoding, default widths and the reset coefficient profile.
package fir_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int DEF_DW    = 12;
    localparam int DEF_FRAC  = 10;
    localparam int DEF_CW    = 12;
    localparam int DEF_CFRAC = 10;
    localparam int DEF_NTAP  = 8;

    // Tap 0 is unity gain, all others zero: a pass-through filter.
    function automatic int reset_coef(input int idx, input int cfrac);
        return (idx == 0) ? (1 << cfrac) : 0;
    endfunction

endpackage

// File: rtl/fir_mac_round_sat.sv
// Round-half-up and narrow the accumulator to the output width.
// FIR_MAC_SAT_EN selects saturation; otherwise the result wraps.
module fir_mac_round_sat #(
    parameter int IW = 27,
    parameter int OW = 12,
    parameter int SH = 10
) (
    input  logic signed [IW-1:0] acc_i,
    output logic signed [OW-1:0] res_o
);

    // One guard bit so adding the half LSB never overflows.
    localparam int XW = IW + 1;
    localparam logic signed [XW-1:0] HALF = XW'(2 ** (SH - 1));

    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] shr;

    // Add half an output LSB, then arithmetic shift (floor).
    always_comb begin
        ext = {acc_i[IW-1], acc_i} + HALF;
        shr = ext >>> SH;
    end

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [XW-1:0] MAXV = XW'((2 ** (OW - 1)) - 1);
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    // Clamp to the representable output range.
    always_comb begin
        if (shr > MAXV) begin
            res_o = MAXV[OW-1:0];
        end else if (shr < MINV) begin
            res_o = MINV[OW-1:0];
        end else begin
            res_o = shr[OW-1:0];
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^shr[XW-1:OW];

    // Keep the low bits only; large sums wrap.
    always_comb begin
        res_o = shr[OW-1:0];
    end
`endif

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential single-multiplier FIR: one tap per clock, IDLE/MAC/OUT.
// Define FIR_MAC_SAT_EN to saturate the output instead of wrapping.
module fir_mac_seq
    import fir_mac_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int FRAC  = DEF_FRAC,
    parameter int CW    = DEF_CW,
    parameter int CFRAC = DEF_CFRAC,
    parameter int NTAP  = DEF_NTAP
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           p,
    input  logic                    p_valid,
    output logic                    p_ready,
    output logic [DW-1:0]           q,
    output logic                    q_valid,
    input  logic                    coef_we,
    input  logic [$clog2(NTAP)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_data
);

    localparam int KW = $clog2(NTAP);
    localparam int AW = DW + CW + KW;

    if (NTAP < 2 || NTAP > 64) begin : g_bad_ntap
        $error("fir_mac_seq: NTAP out of range");
    end
    if (FRAC >= DW) begin : g_bad_frac
        $error("fir_mac_seq: FRAC must be below DW");
    end

    state_e                 state_q, state_d;
    logic signed [DW-1:0]   x_q [NTAP];
    logic signed [CW-1:0]   c_q [NTAP];
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [KW-1:0]          k_q, k_d;
    logic [DW-1:0]          qh_q, qh_d;
    logic signed [DW+CW-1:0] prod;
    logic signed [DW-1:0]   rnd;
    logic                   shift;
    logic                   coef_wr;

    assign prod = x_q[k_q] * c_q[k_q];

    fir_mac_round_sat #(
        .IW(AW),
        .OW(DW),
        .SH(CFRAC)
    ) u_rnd (
        .acc_i(acc_q),
        .res_o(rnd)
    );

    // Next-state, handshake and output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        k_d     = k_q;
        qh_d    = qh_q;
        p_ready = 1'b0;
        q_valid = 1'b0;
        q       = qh_q;
        shift   = 1'b0;
        coef_wr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                p_ready = 1'b1;
                coef_wr = coef_we && (int'(coef_addr) < NTAP);
                if (p_valid) begin
                    shift   = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + AW'(prod);
                if (k_q == KW'(NTAP - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_OUT: begin
                q_valid = 1'b1;
                q       = rnd;
                qh_d    = rnd;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, accumulator, tap counter and held output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            k_q     <= '0;
            qh_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            qh_q    <= qh_d;
        end
    end

    // Delay line shift on accept; coefficient writes only while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NTAP; i++) begin
                x_q[i] <= '0;
                c_q[i] <= CW'(reset_coef(i, CFRAC));
            end
        end else begin
            if (shift) begin
                x_q[0] <= p;
                for (int i = 1; i < NTAP; i++) begin
                    x_q[i] <= x_q[i-1];
                end
            end
            if (coef_wr) begin
                c_q[coef_addr] <= coef_data;
            end
        end
    end

endmodule
